// File: rtl/uart_mmio_if.sv
// uart_mmio_if
//  CPU data-bus bundle shared by the CPU (master) and the uart_mmio peripheral (slave).
//  wr_valid/wr_addr/wr_data : one-cycle write strobe with byte address and data
//  rd_en/rd_addr            : one-cycle read strobe with byte address
//  rd_data/rd_hit           : registered read response, valid the cycle after rd_en
interface uart_mmio_if;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_hit;

    modport master (output wr_valid, wr_addr, wr_data, rd_en, rd_addr,
                    input  rd_data, rd_hit);
    modport slave  (input  wr_valid, wr_addr, wr_data, rd_en, rd_addr,
                    output rd_data, rd_hit);
endinterface

// File: rtl/uart_mmio.sv
// uart_mmio
//  Memory-mapped full-duplex 8N1 UART with TX/RX FIFOs, status/control registers,
//  sticky error flags and a registered level interrupt.
//  Ports:
//   clk, i_reset   system clock, asynchronous active-high reset
//   bus            CPU bus slave (write strobe, read strobe, registered read data/hit)
//   uart_txd_in    serial receive line, asynchronous to clk
//   uart_rxd_out   serial transmit line, idle high
//   irq            level interrupt
//  Register window (16 bytes at BASE_ADDR): +0 TXDATA, +4 RXDATA, +8 STATUS, +C CTRL.
module uart_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          TX_DEPTH     = 16,
    parameter int          RX_DEPTH     = 16
) (
    input  logic       clk,
    input  logic       i_reset,
    uart_mmio_if.slave bus,
    input  logic       uart_txd_in,
    output logic       uart_rxd_out,
    output logic       irq
);
    localparam int TW  = $clog2(CLKS_PER_BIT + 1);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TCW = TAW + 1;
    localparam int RCW = RAW + 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    // Address decode: only bits [31:4] select the window, [3:2] pick the register.
    logic wr_sel, rd_sel, wr_txdata, wr_status, wr_ctrl, rd_rxdata;
    assign wr_sel    = bus.wr_valid && (bus.wr_addr[31:4] == BASE_ADDR[31:4]);
    assign rd_sel    = bus.rd_en && (bus.rd_addr[31:4] == BASE_ADDR[31:4]);
    assign wr_txdata = wr_sel && (bus.wr_addr[3:2] == 2'd0);
    assign wr_status = wr_sel && (bus.wr_addr[3:2] == 2'd2);
    assign wr_ctrl   = wr_sel && (bus.wr_addr[3:2] == 2'd3);
    assign rd_rxdata = rd_sel && (bus.rd_addr[3:2] == 2'd1);

    logic unused_bits;
    assign unused_bits = ^{bus.wr_addr[1:0], bus.wr_data[31:8], bus.rd_addr[1:0]};

    // TX FIFO. A push into a full FIFO still lands when the FSM pops in the same cycle.
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wptr, tx_rptr;
    logic [TCW-1:0] tx_count;
    logic           tx_full, tx_empty, tx_pop, tx_push;
    logic [7:0]     tx_head;
    assign tx_full  = (tx_count == TCW'(TX_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign tx_push  = wr_txdata && (!tx_full || tx_pop);
    assign tx_head  = tx_mem[tx_rptr];

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + TAW'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + TAW'(1);
            tx_count <= tx_count + TCW'(tx_push) - TCW'(tx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= bus.wr_data[7:0];
    end

    // RX FIFO. Pops only on an RXDATA read while non-empty.
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wptr, rx_rptr;
    logic [RCW-1:0] rx_count;
    logic           rx_full, rx_empty, rx_pop, rx_push, rx_push_ok;
    logic [7:0]     rx_head;
    assign rx_full    = (rx_count == RCW'(RX_DEPTH));
    assign rx_empty   = (rx_count == '0);
    assign rx_pop     = rd_rxdata && !rx_empty;
    assign rx_push_ok = rx_push && (!rx_full || rx_pop);
    assign rx_head    = rx_mem[rx_rptr];

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push_ok) rx_wptr <= rx_wptr + RAW'(1);
            if (rx_pop)     rx_rptr <= rx_rptr + RAW'(1);
            rx_count <= rx_count + RCW'(rx_push_ok) - RCW'(rx_pop);
        end
    end

    // RX shift register holds the assembled byte by the time it is pushed.
    logic [7:0] rx_shift;
    always_ff @(posedge clk) begin
        if (rx_push_ok) rx_mem[rx_wptr] <= rx_shift;
    end

    // TX FSM state register. The line register resets high so a reset mid-frame
    // releases the line at once.
    uart_state_t tx_state, tx_state_n;
    logic [TW-1:0] tx_timer, tx_timer_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic          tx_line, tx_line_n, tx_busy;
    assign tx_busy      = (tx_state != S_IDLE);
    assign uart_rxd_out = tx_line;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            tx_state <= S_IDLE;
            tx_timer <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_timer <= tx_timer_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_line  <= tx_line_n;
        end
    end

    // TX next state. The end of STOP pops the next byte directly into START so
    // consecutive frames leave no idle gap on the line.
    always_comb begin
        tx_state_n = tx_state;
        tx_timer_n = tx_timer;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_line_n  = tx_line;
        tx_pop     = 1'b0;
        case (tx_state)
            S_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_n = S_START;
                    tx_timer_n = '0;
                    tx_shift_n = tx_head;
                    tx_line_n  = 1'b0;
                end
            end
            S_START: begin
                tx_timer_n = tx_timer + TW'(1);
                if (tx_timer == BIT_LAST) begin
                    tx_timer_n = '0;
                    tx_bit_n   = '0;
                    tx_line_n  = tx_shift[0];
                    tx_state_n = S_DATA;
                end
            end
            S_DATA: begin
                tx_timer_n = tx_timer + TW'(1);
                if (tx_timer == BIT_LAST) begin
                    tx_timer_n = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = S_STOP;
                        tx_line_n  = 1'b1;
                    end else begin
                        tx_bit_n   = tx_bit + 3'd1;
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        tx_line_n  = tx_shift[1];
                    end
                end
            end
            S_STOP: begin
                tx_timer_n = tx_timer + TW'(1);
                if (tx_timer == BIT_LAST) begin
                    tx_timer_n = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_state_n = S_START;
                        tx_shift_n = tx_head;
                        tx_line_n  = 1'b0;
                    end else begin
                        tx_state_n = S_IDLE;
                    end
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
    end

    // RX synchroniser plus one more flop of history for falling-edge detection.
    logic [1:0] rx_sync;
    logic       rx_in, rx_prev;
    assign rx_in = rx_sync[1];

    uart_state_t rx_state, rx_state_n;
    logic [TW-1:0] rx_timer, rx_timer_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_shift_n;
    logic          rx_ferr;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_timer <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync  <= {rx_sync[0], uart_txd_in};
            rx_prev  <= rx_in;
            rx_state <= rx_state_n;
            rx_timer <= rx_timer_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // RX next state. START re-checks the line half a bit after the edge, which
    // both rejects glitches and aligns the later samples to bit centres.
    always_comb begin
        rx_state_n = rx_state;
        rx_timer_n = rx_timer;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (rx_prev && !rx_in) begin
                    rx_state_n = S_START;
                    rx_timer_n = '0;
                end
            end
            S_START: begin
                rx_timer_n = rx_timer + TW'(1);
                if (rx_timer == HALF_LAST) begin
                    rx_timer_n = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_in ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                rx_timer_n = rx_timer + TW'(1);
                if (rx_timer == BIT_LAST) begin
                    rx_timer_n = '0;
                    rx_shift_n = {rx_in, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_n = S_STOP;
                end
            end
            S_STOP: begin
                rx_timer_n = rx_timer + TW'(1);
                if (rx_timer == BIT_LAST) begin
                    rx_timer_n = '0;
                    rx_state_n = S_IDLE;
                    rx_push    = rx_in;
                    rx_ferr    = !rx_in;
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    // Register read mux; RXDATA reads as zero while the FIFO is empty.
    logic [1:0]  ctrl;
    logic        rx_overrun, frame_err, tx_overflow;
    logic [7:0]  status;
    logic [31:0] rd_word;
    assign status = {tx_overflow, frame_err, tx_busy, rx_overrun,
                     rx_full, rx_empty, tx_empty, tx_full};

    always_comb begin
        rd_word = '0;
        case (bus.rd_addr[3:2])
            2'd1:    rd_word = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_head};
            2'd2:    rd_word = {24'd0, status};
            2'd3:    rd_word = {30'd0, ctrl};
            default: rd_word = '0;
        endcase
    end

    // Control, sticky flags, read response and interrupt. A flag being set in
    // the same cycle as its W1C wins, so no event is lost.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            bus.rd_data <= '0;
            bus.rd_hit  <= 1'b0;
            ctrl        <= '0;
            rx_overrun  <= 1'b0;
            frame_err   <= 1'b0;
            tx_overflow <= 1'b0;
            irq         <= 1'b0;
        end else begin
            bus.rd_hit  <= rd_sel;
            bus.rd_data <= rd_sel ? rd_word : 32'd0;
            if (wr_ctrl) ctrl <= bus.wr_data[1:0];
            if (wr_status && bus.wr_data[4]) rx_overrun  <= 1'b0;
            if (wr_status && bus.wr_data[6]) frame_err   <= 1'b0;
            if (wr_status && bus.wr_data[7]) tx_overflow <= 1'b0;
            if (rx_push && rx_full && !rx_pop)     rx_overrun  <= 1'b1;
            if (rx_ferr)                           frame_err   <= 1'b1;
            if (wr_txdata && tx_full && !tx_pop)   tx_overflow <= 1'b1;
            irq <= (ctrl[0] && !rx_empty) || (ctrl[1] && tx_empty && !tx_busy)
                   || rx_overrun || frame_err;
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio
//  Directed self-checking bench for uart_mmio with CLKS_PER_BIT=4, BASE_ADDR=0x1000
//  and 4-entry FIFOs. Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_mmio;
    localparam logic [31:0] A_TX   = 32'h1000;
    localparam logic [31:0] A_RX   = 32'h1004;
    localparam logic [31:0] A_STAT = 32'h1008;
    localparam logic [31:0] A_CTRL = 32'h100C;

    logic clk, i_reset, uart_txd_in, uart_rxd_out, irq;
    int   vectors, miscompares;

    uart_mmio_if bus();

    uart_mmio #(.BASE_ADDR(32'h0000_1000), .CLKS_PER_BIT(4), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .clk(clk), .i_reset(i_reset), .bus(bus), .uart_txd_in(uart_txd_in),
        .uart_rxd_out(uart_rxd_out), .irq(irq));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, miscompares=%0d", miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    // Ten bit cells (start, 8 data LSB first, stop), each held for four clocks.
    function automatic logic [39:0] exp_frame(input logic [7:0] b);
        logic [9:0]  cells;
        logic [39:0] f;
        cells = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) f[i] = cells[i / 4];
        return f;
    endfunction

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.wr_valid = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic hit);
        @(negedge clk);
        bus.rd_en = 1'b1; bus.rd_addr = addr;
        @(negedge clk);
        bus.rd_en = 1'b0;
        data = bus.rd_data; hit = bus.rd_hit;
    endtask

    // With wait_start set, waits (bounded) for the line to drop; otherwise the
    // current sample is taken as the first cell of a frame that follows directly.
    task automatic capture_frame(input bit wait_start, output logic [39:0] bits, output bit found);
        bits = '1;
        found = !wait_start;
        if (wait_start) begin
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (uart_rxd_out === 1'b0) begin found = 1'b1; break; end
            end
        end
        if (found) begin
            for (int i = 0; i < 40; i++) begin
                bits[i] = uart_rxd_out;
                @(negedge clk);
            end
        end
    endtask

    task automatic send_serial(input logic [7:0] b, input logic stop_bit);
        logic [9:0] cells;
        cells = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_txd_in = cells[i];
            repeat (3) @(negedge clk);
        end
        @(negedge clk);
        uart_txd_in = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        h;
        int          lows;
        i_reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (uart_rxd_out !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_line: got %b expected 1", uart_rxd_out); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
        vectors++; if ({bus.rd_hit, bus.rd_data} !== 33'd0) begin miscompares++; $display("[TB] FAIL reset_rd: got hit=%b data=%h expected 0/0", bus.rd_hit, bus.rd_data); end
        i_reset = 1'b0;
        bus_read(A_STAT, d, h);
        vectors++; if (d !== 32'h06 || h !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_status: got %h hit=%b expected 00000006 hit=1", d, h); end
        bus_read(A_CTRL, d, h);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_ctrl: got %h expected 0", d); end
        bus_read(32'h2008, d, h);
        vectors++; if (h !== 1'b0 || d !== 32'h0) begin miscompares++; $display("[TB] FAIL outside_read: got %h hit=%b expected 0 hit=0", d, h); end
        bus_write(32'h2000, 32'h77);
        lows = 0;
        repeat (20) begin @(negedge clk); if (uart_rxd_out !== 1'b1) lows++; end
        vectors++; if (lows !== 0) begin miscompares++; $display("[TB] FAIL outside_write: got %0d low samples expected 0", lows); end
    endtask

    task automatic test_tx_single();
        logic [39:0] bits;
        logic [31:0] d;
        logic        h;
        bit          found;
        bus_write(A_TX, 32'hA5);
        fork
            capture_frame(1'b1, bits, found);
            begin
                repeat (10) @(negedge clk);
                bus_read(A_STAT, d, h);
                vectors++; if (d !== 32'h26) begin miscompares++; $display("[TB] FAIL tx_busy_status: got %h expected 00000026", d); end
            end
        join
        vectors++; if (!found || bits !== exp_frame(8'hA5)) begin miscompares++; $display("[TB] FAIL tx_frame_a5: got %h found=%b expected %h", bits, found, exp_frame(8'hA5)); end
        vectors++; if (uart_rxd_out !== 1'b1) begin miscompares++; $display("[TB] FAIL tx_idle_after: got %b expected 1", uart_rxd_out); end
        bus_read(A_STAT, d, h);
        vectors++; if (d !== 32'h06) begin miscompares++; $display("[TB] FAIL tx_done_status: got %h expected 00000006", d); end
    endtask

    // The first byte leaves the FIFO one cycle after it lands, so the depth-4
    // FIFO plus the shifter absorbs five consecutive writes; the sixth is dropped.
    task automatic test_back_to_back();
        logic [7:0]  tx_bytes [6];
        logic [39:0] bits [5];
        logic [31:0] d;
        logic        h;
        bit          found;
        tx_bytes = '{8'h55, 8'h0F, 8'hF0, 8'h81, 8'h3C, 8'hC3};
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    bus.wr_valid = 1'b1; bus.wr_addr = A_TX; bus.wr_data = {24'd0, tx_bytes[i]};
                end
                @(negedge clk);
                bus.wr_valid = 1'b0;
            end
            begin
                capture_frame(1'b1, bits[0], found);
                for (int f = 1; f < 5; f++) begin
                    logic [39:0] tmp;
                    bit          dummy;
                    capture_frame(1'b0, tmp, dummy);
                    bits[f] = tmp;
                end
            end
        join
        vectors++; if (!found) begin miscompares++; $display("[TB] FAIL b2b_start: no start bit seen, got found=0 expected 1"); end
        for (int f = 0; f < 5; f++) begin
            vectors++; if (bits[f] !== exp_frame(tx_bytes[f])) begin miscompares++; $display("[TB] FAIL b2b_frame%0d: got %h expected %h", f, bits[f], exp_frame(tx_bytes[f])); end
        end
        vectors++; if (uart_rxd_out !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_sixth_dropped: got line %b expected 1", uart_rxd_out); end
        bus_read(A_STAT, d, h);
        vectors++; if (d !== 32'h86) begin miscompares++; $display("[TB] FAIL tx_overflow_set: got %h expected 00000086", d); end
        bus_write(A_STAT, 32'h80);
        bus_read(A_STAT, d, h);
        vectors++; if (d !== 32'h06) begin miscompares++; $display("[TB] FAIL tx_overflow_w1c: got %h expected 00000006", d); end
    endtask

    task automatic test_rx_single();
        logic [31:0] d;
        logic        h;
        send_serial(8'h3C, 1'b1);
        repeat (3) @(negedge clk);
        bus_read(A_RX, d, h);
        vectors++; if (d !== 32'h13C || h !== 1'b1) begin miscompares++; $display("[TB] FAIL rx_read_3c: got %h hit=%b expected 0000013c hit=1", d, h); end
        bus_read(A_RX, d, h);
        vectors++; if (d !== 32'h0 || h !== 1'b1) begin miscompares++; $display("[TB] FAIL rx_read_empty: got %h hit=%b expected 0 hit=1", d, h); end
    endtask

    task automatic test_ctrl_irq();
        logic [31:0] d;
        logic        h;
        // Write and read CTRL in the same cycle: the read sees the old value.
        @(negedge clk);
        bus.wr_valid = 1'b1; bus.wr_addr = A_CTRL; bus.wr_data = 32'hFFFF_FFFF;
        bus.rd_en = 1'b1; bus.rd_addr = A_CTRL;
        @(negedge clk);
        bus.wr_valid = 1'b0; bus.rd_en = 1'b0;
        vectors++; if (bus.rd_data !== 32'h0 || bus.rd_hit !== 1'b1) begin miscompares++; $display("[TB] FAIL same_cycle_rw: got %h hit=%b expected 0 hit=1", bus.rd_data, bus.rd_hit); end
        bus_read(A_CTRL, d, h);
        vectors++; if (d !== 32'h3) begin miscompares++; $display("[TB] FAIL ctrl_readback: got %h expected 00000003", d); end
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL txe_irq: got %b expected 1", irq); end
        bus_write(A_CTRL, 32'h1);
        repeat (2) @(negedge clk);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL rx_irq_idle: got %b expected 0", irq); end
        send_serial(8'h7E, 1'b1);
        repeat (3) @(negedge clk);
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL rx_irq_data: got %b expected 1", irq); end
        bus_read(A_RX, d, h);
        vectors++; if (d !== 32'h17E) begin miscompares++; $display("[TB] FAIL rx_read_7e: got %h expected 0000017e", d); end
        repeat (2) @(negedge clk);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL rx_irq_drained: got %b expected 0", irq); end
        bus_write(A_CTRL, 32'h0);
    endtask

    task automatic test_rx_overrun();
        logic [7:0]  rx_bytes [5];
        logic [31:0] d;
        logic        h;
        rx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) send_serial(rx_bytes[i], 1'b1);
        repeat (3) @(negedge clk);
        bus_read(A_STAT, d, h);
        vectors++; if (d !== 32'h1A) begin miscompares++; $display("[TB] FAIL overrun_status: got %h expected 0000001a", d); end
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL overrun_irq: got %b expected 1", irq); end
        for (int i = 0; i < 4; i++) begin
            bus_read(A_RX, d, h);
            vectors++; if (d !== {23'd0, 1'b1, rx_bytes[i]}) begin miscompares++; $display("[TB] FAIL overrun_read%0d: got %h expected %h", i, d, {23'd0, 1'b1, rx_bytes[i]}); end
        end
        bus_read(A_RX, d, h);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL overrun_fifth: got %h expected 0", d); end
        bus_write(A_STAT, 32'h10);
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL irq_hold_w1c: got %b expected 1", irq); end
        @(negedge clk);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_drop_w1c: got %b expected 0", irq); end
    endtask

    task automatic test_rx_errors();
        logic [31:0] d;
        logic        h;
        send_serial(8'h5A, 1'b0);
        repeat (3) @(negedge clk);
        bus_read(A_STAT, d, h);
        vectors++; if (d !== 32'h46) begin miscompares++; $display("[TB] FAIL frame_err_status: got %h expected 00000046", d); end
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("[TB] FAIL frame_err_irq: got %b expected 1", irq); end
        repeat (10) @(negedge clk);
        @(negedge clk); uart_txd_in = 1'b0;
        @(negedge clk); uart_txd_in = 1'b1;
        repeat (50) @(negedge clk);
        bus_read(A_STAT, d, h);
        vectors++; if (d !== 32'h46) begin miscompares++; $display("[TB] FAIL glitch_reject: got %h expected 00000046", d); end
        bus_write(A_STAT, 32'h40);
        bus_read(A_STAT, d, h);
        vectors++; if (d !== 32'h06) begin miscompares++; $display("[TB] FAIL frame_err_w1c: got %h expected 00000006", d); end
        send_serial(8'hC3, 1'b1);
        repeat (3) @(negedge clk);
        bus_read(A_RX, d, h);
        vectors++; if (d !== 32'h1C3) begin miscompares++; $display("[TB] FAIL rx_after_glitch: got %h expected 000001c3", d); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        logic        h;
        int          lows;
        bus_write(A_TX, 32'h00);
        bus_write(A_TX, 32'h12);
        bus_write(A_TX, 32'h34);
        repeat (12) @(negedge clk);
        vectors++; if (uart_rxd_out !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_frame_low: got %b expected 0", uart_rxd_out); end
        i_reset = 1'b1;
        #1;
        vectors++; if (uart_rxd_out !== 1'b1) begin miscompares++; $display("[TB] FAIL async_reset_line: got %b expected 1", uart_rxd_out); end
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        lows = 0;
        repeat (50) begin @(negedge clk); if (uart_rxd_out !== 1'b1) lows++; end
        vectors++; if (lows !== 0) begin miscompares++; $display("[TB] FAIL reset_flush_tx: got %0d low samples expected 0", lows); end
        bus_read(A_STAT, d, h);
        vectors++; if (d !== 32'h06) begin miscompares++; $display("[TB] FAIL post_reset_status: got %h expected 00000006", d); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        i_reset = 1'b0;
        uart_txd_in = 1'b1;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;
        $display("[TB] starting uart_mmio directed tests");
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx_single();
        test_ctrl_irq();
        test_rx_overrun();
        test_rx_errors();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
